// File: rtl/exec_stage_if.sv
// Instruction / data-RAM / fetch-feedback bundle for the execute stage.
// Handshake: an instruction is taken on a rising edge only when OP_VALID is 1
// and the stage is in RUN (BUSY = 0). While BUSY or HALTED is high, the
// driver may hold or pulse OP_VALID freely. Any instruction presented in that
// window is dropped, with no side effects. RAM_RDATA must reflect RAM_ADDR
// within the cycle after the load issues. RAM_WE is a single-cycle write
// strobe qualifying RAM_ADDR/RAM_WDATA.
interface exec_stage_if #(
    parameter int REG_W = 16,
    parameter int PC_W  = 8
);
    logic             OP_VALID;
    logic [3:0]       OP_CODE;
    logic [2:0]       OP_REG_A;
    logic [7:0]       OP_DATA;
    logic [PC_W-1:0]  RAM_ADDR;
    logic [REG_W-1:0] RAM_WDATA;
    logic             RAM_WE;
    logic [REG_W-1:0] RAM_RDATA;
    logic [PC_W-1:0]  PC_OUT;
    logic             BUSY;
    logic             HALTED;
    logic             FLAG_EQ;

    // Upstream side: decoder plus data RAM.
    modport master (
        output OP_VALID, OP_CODE, OP_REG_A, OP_DATA, RAM_RDATA,
        input  RAM_ADDR, RAM_WDATA, RAM_WE, PC_OUT, BUSY, HALTED, FLAG_EQ
    );

    // Execute stage side.
    modport slave (
        input  OP_VALID, OP_CODE, OP_REG_A, OP_DATA, RAM_RDATA,
        output RAM_ADDR, RAM_WDATA, RAM_WE, PC_OUT, BUSY, HALTED, FLAG_EQ
    );
endinterface

// File: rtl/exec_stage.sv
// Execute stage of the 15-bit CPU. It holds the 8 x 16 register file, the
// compare flag and the PC, and it drives the data-RAM port. A load takes two
// cycles because of the LD_WAIT stall. hlt parks the stage in HALT until reset.
// DBG_STATE: 0 = RUN, 1 = LD_WAIT, 2 = HALT. DBG_REGS mirrors the register file.
module exec_stage #(
    parameter int REG_W = 16,
    parameter int PC_W  = 8
) (
    input  logic                  CLK_EX,
    input  logic                  RESET,
    exec_stage_if.slave           bus,
    output logic [1:0]            DBG_STATE,
    output logic [7:0][REG_W-1:0] DBG_REGS
);
    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_LD_WAIT = 2'd1,
        S_HALT    = 2'd2
    } state_t;

    localparam logic [3:0] OP_MOV = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3,
                           OP_OR  = 4'h4, OP_SL  = 4'h5, OP_SR  = 4'h6, OP_SRA = 4'h7,
                           OP_LDL = 4'h8, OP_LDH = 4'h9, OP_CMP = 4'hA, OP_JE  = 4'hB,
                           OP_JMP = 4'hC, OP_LD  = 4'hD, OP_ST  = 4'hE, OP_HLT = 4'hF;

    state_t           state_q, state_d;
    logic [REG_W-1:0] regs_q [8];
    logic [REG_W-1:0] regs_d [8];
    logic [PC_W-1:0]  pc_q, pc_d;
    logic             flag_q, flag_d;
    logic [PC_W-1:0]  ram_addr_q, ram_addr_d;
    logic [REG_W-1:0] ram_wdata_q, ram_wdata_d;
    logic             ram_we_q, ram_we_d;
    logic             busy_q, busy_d;
    logic             halted_q, halted_d;
    logic [2:0]       ld_dst_q, ld_dst_d;
    logic [REG_W-1:0] a_val, b_val;
    logic [PC_W-1:0]  pc_inc, imm_pc;

    // State register; async reset abandons any in-flight load.
    always_ff @(posedge CLK_EX or posedge RESET) begin
        if (RESET) begin
            state_q     <= S_RUN;
            regs_q      <= '{default: '0};
            pc_q        <= '0;
            flag_q      <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
            ld_dst_q    <= '0;
        end else begin
            state_q     <= state_d;
            regs_q      <= regs_d;
            pc_q        <= pc_d;
            flag_q      <= flag_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_we_q    <= ram_we_d;
            busy_q      <= busy_d;
            halted_q    <= halted_d;
            ld_dst_q    <= ld_dst_d;
        end
    end

    // Next-state and datapath; operands are read from pre-edge register values.
    always_comb begin
        state_d     = state_q;
        regs_d      = regs_q;
        pc_d        = pc_q;
        flag_d      = flag_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_we_d    = 1'b0;
        busy_d      = busy_q;
        halted_d    = halted_q;
        ld_dst_d    = ld_dst_q;
        a_val       = regs_q[bus.OP_REG_A];
        b_val       = regs_q[bus.OP_DATA[7:5]];
        pc_inc      = pc_q + PC_W'(1);
        imm_pc      = PC_W'(bus.OP_DATA);

        unique case (state_q)
            S_RUN: begin
                if (bus.OP_VALID) begin
                    pc_d = pc_inc;
                    unique case (bus.OP_CODE)
                        OP_MOV: regs_d[bus.OP_REG_A] = b_val;
                        OP_ADD: regs_d[bus.OP_REG_A] = a_val + b_val;
                        OP_SUB: regs_d[bus.OP_REG_A] = a_val - b_val;
                        OP_AND: regs_d[bus.OP_REG_A] = a_val & b_val;
                        OP_OR:  regs_d[bus.OP_REG_A] = a_val | b_val;
                        OP_SL:  regs_d[bus.OP_REG_A] = {a_val[REG_W-2:0], 1'b0};
                        OP_SR:  regs_d[bus.OP_REG_A] = {1'b0, a_val[REG_W-1:1]};
                        OP_SRA: regs_d[bus.OP_REG_A] = {a_val[REG_W-1], a_val[REG_W-1:1]};
                        OP_LDL: regs_d[bus.OP_REG_A] = {a_val[REG_W-1:8], bus.OP_DATA};
                        OP_LDH: regs_d[bus.OP_REG_A] = {bus.OP_DATA, a_val[7:0]};
                        OP_CMP: flag_d = (a_val == b_val);
                        OP_JE:  pc_d = flag_q ? imm_pc : pc_inc;
                        OP_JMP: pc_d = imm_pc;
                        OP_LD: begin
                            // PC advances when the data lands, not at issue.
                            pc_d       = pc_q;
                            ram_addr_d = imm_pc;
                            busy_d     = 1'b1;
                            ld_dst_d   = bus.OP_REG_A;
                            state_d    = S_LD_WAIT;
                        end
                        OP_ST: begin
                            ram_addr_d  = imm_pc;
                            ram_wdata_d = a_val;
                            ram_we_d    = 1'b1;
                        end
                        OP_HLT: begin
                            pc_d     = pc_q;
                            halted_d = 1'b1;
                            busy_d   = 1'b1;
                            state_d  = S_HALT;
                        end
                        default: ;
                    endcase
                end
            end
            S_LD_WAIT: begin
                regs_d[ld_dst_q] = bus.RAM_RDATA;
                pc_d             = pc_inc;
                busy_d           = 1'b0;
                state_d          = S_RUN;
            end
            S_HALT: ;
            default: state_d = S_RUN;
        endcase
    end

    // Registered outputs and debug taps.
    always_comb begin
        bus.RAM_ADDR  = ram_addr_q;
        bus.RAM_WDATA = ram_wdata_q;
        bus.RAM_WE    = ram_we_q;
        bus.PC_OUT    = pc_q;
        bus.BUSY      = busy_q;
        bus.HALTED    = halted_q;
        bus.FLAG_EQ   = flag_q;
        DBG_STATE     = state_q;
        for (int i = 0; i < 8; i++) DBG_REGS[i] = regs_q[i];
    end
endmodule

// File: doc/exec_stage.md
Name: exec_stage

Overview:
- Execute stage of the 15-bit CPU. Sits directly downstream of the decoder and consumes its registered OP_CODE / OP_DATA plus the destination-register field.
- Holds the 8 x 16-bit register file, the compare flag and the program counter.
- Drives the data-RAM port and feeds PC_OUT back to the fetch stage.
- Has a multi-cycle load, a halt state, and a BUSY stall to fetch/decode.

Parameters:
- REG_W, 16, register and data-memory word width.
- PC_W, 8, program-counter and data-address width.

Ports:
- CLK_EX  input  1  stage clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- OP_VALID  input  1  OP_CODE/OP_REG_A/OP_DATA hold a new instruction this cycle.
- OP_CODE  input  4  opcode (instruction bits 14:11).
- OP_REG_A  input  3  destination/first register (bits 10:8).
- OP_DATA  input  8  immediate/address (bits 7:0); bits 7:5 are register B.
- RAM_ADDR  output  8  data-RAM address.
- RAM_WDATA  output  16  data-RAM write data.
- RAM_WE  output  1  data-RAM write strobe, one cycle.
- RAM_RDATA  input  16  data-RAM read data, valid one cycle after RAM_ADDR.
- PC_OUT  output  8  program counter to fetch.
- BUSY  output  1  fetch/decode must hold; OP_VALID is ignored while high.
- HALTED  output  1  hlt executed.
- FLAG_EQ  output  1  result of last cmp.

Behaviour:
- Reset (async, any state):
  - All registers = 0.
  - PC_OUT = 0, FLAG_EQ = 0, RAM_WE = 0, RAM_ADDR = 0, RAM_WDATA = 0, BUSY = 0, HALTED = 0.
  - State = RUN.
  - An in-flight ld is abandoned; its destination register stays 0.
- States:
  - RUN: executes on OP_VALID = 1.
  - LD_WAIT: one cycle, BUSY = 1.
  - HALT: terminal until RESET.
- Opcodes, executed in one cycle in RUN unless noted. A = reg[OP_REG_A], B = reg[OP_DATA[7:5]].
  - 0000 mov: A <= B.
  - 0001 add: A <= A + B.
  - 0010 sub: A <= A - B.
  - 0011 and: A <= A & B.
  - 0100 or: A <= A | B.
  - 0101 sl: A <= A << 1, zero fill.
  - 0110 sr: A <= A >> 1, zero fill.
  - 0111 sra: A <= A >> 1, sign fill.
  - 1000 ldl: A[7:0] <= OP_DATA; A[15:8] kept.
  - 1001 ldh: A[15:8] <= OP_DATA; A[7:0] kept.
  - 1010 cmp: FLAG_EQ <= (A == B); no register write.
  - 1011 je: PC <= OP_DATA if FLAG_EQ = 1, else PC + 1.
  - 1100 jmp: PC <= OP_DATA.
  - 1101 ld: RAM_ADDR <= OP_DATA, BUSY <= 1, go to LD_WAIT. Next cycle: A <= RAM_RDATA, PC + 1, BUSY <= 0, return to RUN. 2 cycles total.
  - 1110 st: RAM_ADDR <= OP_DATA, RAM_WDATA <= A, RAM_WE <= 1 for exactly one cycle.
  - 1111 hlt: HALTED <= 1, BUSY <= 1, go to HALT; PC frozen.
- PC: every non-jump instruction does PC + 1. PC wraps 255 -> 0.
- Arithmetic: 16-bit modulo; no carry/overflow flag.
- Only cmp writes FLAG_EQ; the flag persists across all other instructions.
- OP_VALID = 0 in RUN: no state change; RAM_WE = 0.
- Outputs are registered; results are visible the cycle after the executing edge.
- Same-register operands (A = B, e.g. add R1,R1) use pre-edge values: add R1,R1 doubles R1.
- OP_VALID while BUSY or in HALT: ignored, no side effects.

Test Plan:
- Reset released, then ldh R3,0x12 / ldl R3,0x34 -> reg3 = 0x1234; PC_OUT steps 0 -> 1 -> 2.
- R1 = 0xFFFF, R2 = 1, add R1,R2 -> R1 = 0x0000; FLAG_EQ unchanged. Then R1 = 0x8002, sra R1 -> 0xC001; sr R1 -> 0x6000.
- Sum loop: R0 = 0, R1 = 1, R2 = 0, R3 = 10; add R2,R1; add R0,R2; st R0,0x40; cmp R2,R3; je 14; jmp 8. -> RAM[0x40] writes 1, 3, 6 … 55; je taken once with PC = 14; hlt -> HALTED = 1, PC_OUT = 14 stays frozen.
- st R0,0x40 then ld R5,0x40 -> RAM_WE high exactly one cycle; ld holds BUSY one cycle; R5 = stored value; an OP_VALID pulse during BUSY is ignored.
- jmp 0xFF then a non-jump -> PC_OUT = 0x00 (wrap).
- RESET asserted mid-LD_WAIT -> all outputs 0 immediately (async); R5 = 0; state = RUN after release.
